// File: rtl/axilite_slave_regs_if.sv
// AXI4-Lite bus bundle between the register-file slave and its master.
// Signal names follow the AXI4-Lite channel names.
interface axilite_slave_regs_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);

    logic [AXI_ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]                  AWPROT;
    logic                        AWVALID;
    logic                        AWREADY;
    logic [AXI_DATA_WIDTH-1:0]   WDATA;
    logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
    logic                        WVALID;
    logic                        WREADY;
    logic [1:0]                  BRESP;
    logic                        BVALID;
    logic                        BREADY;
    logic [AXI_ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]                  ARPROT;
    logic                        ARVALID;
    logic                        ARREADY;
    logic [AXI_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                  RRESP;
    logic                        RVALID;
    logic                        RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axilite_slave_regs.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit registers, byte-strobed writes,
// single outstanding write and read, SLVERR on out-of-range addresses.
module axilite_slave_regs #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS       = 8
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    axilite_slave_regs_if.slave                axi,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o
);

    localparam int unsigned IdxW  = $clog2(NUM_REGS);
    localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] AddrLimit = AXI_ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [0:0] {RIdle, RResp} rstate_e;

    // Holds all readies low until the first edge after reset is released.
    logic ready_en_q;

    logic                      aw_full_q, aw_full_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                      w_full_q, w_full_d;
    logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [StrbW-1:0]          w_strb_q, w_strb_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];

    rstate_e                   rstate_q, rstate_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;

    logic            aw_hs, w_hs, ar_hs;
    logic            aw_in_range, ar_in_range;
    logic [IdxW-1:0] aw_idx, ar_idx;
    logic            unused_prot;

    assign unused_prot = ^{axi.AWPROT, axi.ARPROT};

    assign axi.AWREADY = ready_en_q && !aw_full_q && !bvalid_q;
    assign axi.WREADY  = ready_en_q && !w_full_q && !bvalid_q;
    assign axi.BVALID  = bvalid_q;
    assign axi.BRESP   = bresp_q;
    assign axi.ARREADY = ready_en_q && (rstate_q == RIdle);
    assign axi.RVALID  = (rstate_q == RResp);
    assign axi.RDATA   = rdata_q;
    assign axi.RRESP   = rresp_q;

    assign aw_hs = axi.AWVALID && axi.AWREADY;
    assign w_hs  = axi.WVALID && axi.WREADY;
    assign ar_hs = axi.ARVALID && axi.ARREADY;

    assign aw_idx      = aw_addr_q[IdxW+1:2];
    assign aw_in_range = aw_addr_q < AddrLimit;
    assign ar_idx      = axi.ARADDR[IdxW+1:2];
    assign ar_in_range = axi.ARADDR < AddrLimit;

    // Write path: independent address and data slots, commit once both are full.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;

        if (aw_full_q && w_full_q) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (aw_in_range) begin
                bresp_d = RespOkay;
                for (int unsigned b = 0; b < StrbW; b++) begin
                    if (w_strb_q[b]) begin
                        regs_d[aw_idx][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end else begin
                bresp_d = RespSlverr;
            end
        end else begin
            if (aw_hs) begin
                aw_full_d = 1'b1;
                aw_addr_d = axi.AWADDR;
            end
            if (w_hs) begin
                w_full_d = 1'b1;
                w_data_d = axi.WDATA;
                w_strb_d = axi.WSTRB;
            end
        end

        if (bvalid_q && axi.BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Read path: regs_q is sampled before any same-edge commit lands.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            RIdle: begin
                if (ar_hs) begin
                    rstate_d = RResp;
                    if (ar_in_range) begin
                        rdata_d = regs_q[ar_idx];
                        rresp_d = RespOkay;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RespSlverr;
                    end
                end
            end
            RResp: begin
                if (axi.RREADY) begin
                    rstate_d = RIdle;
                end
            end
            default: rstate_d = RIdle;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en_q <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rstate_q   <= RIdle;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
        end else begin
            ready_en_q <= 1'b1;
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            rstate_q   <= rstate_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axilite_slave_regs.sv
// Directed bench for axilite_slave_regs: reset, writes, strobes, decode range,
// backpressure, same-edge read/commit ordering and reset during a write.
module tb_axilite_slave_regs;

    logic ACLK;
    logic ARESET;
    logic [8*32-1:0] regs_o;
    logic [31:0] exp_regs [8];
    logic [8*32-1:0] exp_flat;
    int vectors;
    int miscompares;

    axilite_slave_regs_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) axi ();

    axilite_slave_regs #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .NUM_REGS(8)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .axi(axi),
        .regs_o(regs_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] reg_at(input int i);
        return regs_o[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        bit aw_done = 0;
        bit w_done = 0;
        bit b_done = 0;
        resp = 2'bxx;
        axi.AWADDR = addr; axi.AWVALID = 1'b1;
        axi.WDATA = data; axi.WSTRB = strb; axi.WVALID = 1'b1;
        axi.BREADY = 1'b1;
        for (int c = 0; c < 20 && !b_done; c++) begin
            if (axi.AWVALID && axi.AWREADY) aw_done = 1;
            if (axi.WVALID && axi.WREADY) w_done = 1;
            if (axi.BVALID && axi.BREADY) begin b_done = 1; resp = axi.BRESP; end
            tick();
            if (aw_done) axi.AWVALID = 1'b0;
            if (w_done) axi.WVALID = 1'b0;
        end
        axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
        ok = b_done;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
        bit ar_done = 0;
        bit r_done = 0;
        data = 'x; resp = 2'bxx;
        axi.ARADDR = addr; axi.ARVALID = 1'b1; axi.RREADY = 1'b1;
        for (int c = 0; c < 20 && !r_done; c++) begin
            if (axi.ARVALID && axi.ARREADY) ar_done = 1;
            if (axi.RVALID && axi.RREADY) begin r_done = 1; data = axi.RDATA; resp = axi.RRESP; end
            tick();
            if (ar_done) axi.ARVALID = 1'b0;
        end
        axi.ARVALID = 1'b0; axi.RREADY = 1'b0;
        ok = r_done;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        axi.AWADDR = '0; axi.AWPROT = '0; axi.AWVALID = 0;
        axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 0; axi.BREADY = 0;
        axi.ARADDR = '0; axi.ARPROT = '0; axi.ARVALID = 0; axi.RREADY = 0;
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        repeat (3) @(posedge ACLK);
        #1;
        vectors++;
        if ({axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_held_ctl: got %b want 00000",
                     {axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID});
        end
        vectors++;
        if (regs_o !== '0) begin miscompares++; $display("FAIL rst_regs: got %h want 0", regs_o); end
        ARESET = 1'b0;
        #1;
        vectors++;
        if ({axi.AWREADY, axi.WREADY, axi.ARREADY} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_ready_early: got %b want 000", {axi.AWREADY, axi.WREADY, axi.ARREADY});
        end
        tick();
        vectors++;
        if ({axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID} !== 5'b11100) begin
            miscompares++;
            $display("FAIL rst_release_ctl: got %b want 11100",
                     {axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID});
        end
        vectors++;
        if ({axi.BRESP, axi.RRESP, axi.RDATA} !== 36'h0) begin
            miscompares++;
            $display("FAIL rst_resp_data: got %h want 0", {axi.BRESP, axi.RRESP, axi.RDATA});
        end
    endtask

    task automatic test_simultaneous_write();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        axi.AWADDR = 32'h08; axi.AWVALID = 1;
        axi.WDATA = 32'hDEADBEEF; axi.WSTRB = 4'hF; axi.WVALID = 1; axi.BREADY = 1;
        tick();
        axi.AWVALID = 0; axi.WVALID = 0;
        vectors++;
        if (axi.BVALID !== 1'b0 || reg_at(2) !== 32'h0) begin
            miscompares++;
            $display("FAIL simw_early: bvalid %b reg2 %h want 0 / 0", axi.BVALID, reg_at(2));
        end
        tick();
        exp_regs[2] = 32'hDEADBEEF;
        vectors++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00) begin
            miscompares++;
            $display("FAIL simw_bresp: got bvalid %b bresp %b want 1 00", axi.BVALID, axi.BRESP);
        end
        vectors++;
        if (reg_at(2) !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL simw_reg2: got %h want deadbeef", reg_at(2));
        end
        tick();
        axi.BREADY = 0;
        vectors++;
        if (axi.BVALID !== 1'b0 || axi.AWREADY !== 1'b1 || axi.WREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL simw_bdone: got bvalid %b awready %b wready %b want 0 1 1",
                     axi.BVALID, axi.AWREADY, axi.WREADY);
        end
        do_read(32'h08, d, r, ok);
        vectors++;
        if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
            miscompares++;
            $display("FAIL simw_read: got ok %0b data %h resp %b want 1 deadbeef 00", ok, d, r);
        end
    endtask

    task automatic test_read_during_commit();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        axi.AWADDR = 32'h10; axi.AWVALID = 1;
        axi.WDATA = 32'h5A5A0001; axi.WSTRB = 4'hF; axi.WVALID = 1;
        tick();
        axi.AWVALID = 0; axi.WVALID = 0;
        axi.ARADDR = 32'h10; axi.ARVALID = 1; axi.RREADY = 0;
        tick();
        axi.ARVALID = 0;
        exp_regs[4] = 32'h5A5A0001;
        vectors++;
        if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'h0 || reg_at(4) !== 32'h5A5A0001) begin
            miscompares++;
            $display("FAIL rdcommit_old: got rvalid %b rdata %h reg4 %h want 1 0 5a5a0001",
                     axi.RVALID, axi.RDATA, reg_at(4));
        end
        axi.BREADY = 1; axi.RREADY = 1;
        tick();
        axi.BREADY = 0; axi.RREADY = 0;
        vectors++;
        if (axi.ARREADY !== 1'b1 || axi.RVALID !== 1'b0 || axi.BVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL rdcommit_idle: got arready %b rvalid %b bvalid %b want 1 0 0",
                     axi.ARREADY, axi.RVALID, axi.BVALID);
        end
        do_read(32'h10, d, r, ok);
        vectors++;
        if (!ok || d !== 32'h5A5A0001 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL rdcommit_new: got ok %0b data %h resp %b want 1 5a5a0001 00", ok, d, r);
        end
    endtask

    task automatic test_skewed_strobe();
        logic [1:0] r;
        bit ok;
        do_write(32'h0C, 32'hAABBCCDD, 4'hF, r, ok);
        vectors++;
        if (!ok || r !== 2'b00 || reg_at(3) !== 32'hAABBCCDD) begin
            miscompares++;
            $display("FAIL skew_pre: got ok %0b resp %b reg3 %h want 1 00 aabbccdd", ok, r, reg_at(3));
        end
        axi.WDATA = 32'h11223344; axi.WSTRB = 4'b0101; axi.WVALID = 1; axi.BREADY = 1;
        tick();
        axi.WVALID = 0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (axi.WREADY !== 1'b0 || axi.AWREADY !== 1'b1 || axi.BVALID !== 1'b0) begin
                miscompares++;
                $display("FAIL skew_wait%0d: got wready %b awready %b bvalid %b want 0 1 0",
                         c, axi.WREADY, axi.AWREADY, axi.BVALID);
            end
            if (c < 2) tick();
        end
        axi.AWADDR = 32'h0C; axi.AWVALID = 1;
        tick();
        axi.AWVALID = 0;
        vectors++;
        if (axi.BVALID !== 1'b0 || reg_at(3) !== 32'hAABBCCDD) begin
            miscompares++;
            $display("FAIL skew_early: got bvalid %b reg3 %h want 0 aabbccdd", axi.BVALID, reg_at(3));
        end
        tick();
        exp_regs[3] = 32'hAA22CC44;
        vectors++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00 || reg_at(3) !== 32'hAA22CC44) begin
            miscompares++;
            $display("FAIL skew_commit: got bvalid %b bresp %b reg3 %h want 1 00 aa22cc44",
                     axi.BVALID, axi.BRESP, reg_at(3));
        end
        tick();
        tick();
        axi.BREADY = 0;
        vectors++;
        if (axi.BVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL skew_single_b: got bvalid %b want 0", axi.BVALID);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        do_write(32'h20, 32'hFFFFFFFF, 4'hF, r, ok);
        for (int i = 0; i < 8; i++) exp_flat[i*32 +: 32] = exp_regs[i];
        vectors++;
        if (!ok || r !== 2'b10) begin
            miscompares++;
            $display("FAIL oor_bresp: got ok %0b resp %b want 1 10", ok, r);
        end
        vectors++;
        if (regs_o !== exp_flat) begin
            miscompares++;
            $display("FAIL oor_regs: got %h want %h", regs_o, exp_flat);
        end
        do_read(32'h40, d, r, ok);
        vectors++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            miscompares++;
            $display("FAIL oor_read: got ok %0b data %h resp %b want 1 0 10", ok, d, r);
        end
        // Last register with nonzero low address bits still decodes in range.
        do_write(32'h1F, 32'h0BADF00D, 4'hF, r, ok);
        exp_regs[7] = 32'h0BADF00D;
        vectors++;
        if (!ok || r !== 2'b00 || reg_at(7) !== 32'h0BADF00D) begin
            miscompares++;
            $display("FAIL top_write: got ok %0b resp %b reg7 %h want 1 00 0badf00d", ok, r, reg_at(7));
        end
        do_read(32'h1C, d, r, ok);
        vectors++;
        if (!ok || d !== 32'h0BADF00D || r !== 2'b00) begin
            miscompares++;
            $display("FAIL top_read: got ok %0b data %h resp %b want 1 0badf00d 00", ok, d, r);
        end
    endtask

    task automatic test_backpressure();
        axi.AWADDR = 32'h04; axi.AWVALID = 1;
        axi.WDATA = 32'h0000CAFE; axi.WSTRB = 4'hF; axi.WVALID = 1;
        axi.ARADDR = 32'h08; axi.ARVALID = 1;
        axi.BREADY = 0; axi.RREADY = 0;
        tick();
        axi.AWVALID = 0; axi.WVALID = 0; axi.ARVALID = 0;
        tick();
        exp_regs[1] = 32'h0000CAFE;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00 || axi.RVALID !== 1'b1 ||
                axi.RDATA !== 32'hDEADBEEF || axi.RRESP !== 2'b00 ||
                {axi.AWREADY, axi.WREADY, axi.ARREADY} !== 3'b000) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got b %b/%b r %b/%h/%b rdy %b want 1/00 1/deadbeef/00 000",
                         c, axi.BVALID, axi.BRESP, axi.RVALID, axi.RDATA, axi.RRESP,
                         {axi.AWREADY, axi.WREADY, axi.ARREADY});
            end
            tick();
        end
        axi.BREADY = 1; axi.RREADY = 1;
        tick();
        axi.BREADY = 0; axi.RREADY = 0;
        vectors++;
        if ({axi.BVALID, axi.RVALID, axi.AWREADY, axi.WREADY, axi.ARREADY} !== 5'b00111) begin
            miscompares++;
            $display("FAIL bp_release: got %b want 00111",
                     {axi.BVALID, axi.RVALID, axi.AWREADY, axi.WREADY, axi.ARREADY});
        end
        tick();
        vectors++;
        if (axi.BVALID !== 1'b0 || axi.RVALID !== 1'b0 || reg_at(1) !== 32'h0000CAFE) begin
            miscompares++;
            $display("FAIL bp_single: got bvalid %b rvalid %b reg1 %h want 0 0 0000cafe",
                     axi.BVALID, axi.RVALID, reg_at(1));
        end
    endtask

    task automatic test_reset_mid_write();
        axi.AWADDR = 32'h18; axi.AWVALID = 1;
        tick();
        axi.AWVALID = 0;
        vectors++;
        if (axi.AWREADY !== 1'b0 || axi.WREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_slot: got awready %b wready %b want 0 1", axi.AWREADY, axi.WREADY);
        end
        ARESET = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        vectors++;
        if (regs_o !== '0 || axi.AWREADY !== 1'b0 || axi.WREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async: got regs %h awready %b wready %b want 0 0 0",
                     regs_o, axi.AWREADY, axi.WREADY);
        end
        tick();
        tick();
        ARESET = 1'b0;
        tick();
        vectors++;
        if (axi.AWREADY !== 1'b1 || axi.WREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_clear: got awready %b wready %b want 1 1", axi.AWREADY, axi.WREADY);
        end
        axi.WDATA = 32'h12345678; axi.WSTRB = 4'hF; axi.WVALID = 1; axi.BREADY = 1;
        tick();
        axi.WVALID = 0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (axi.BVALID !== 1'b0 || regs_o !== '0) begin
                miscompares++;
                $display("FAIL midrst_nowrite%0d: got bvalid %b regs %h want 0 0", c, axi.BVALID, regs_o);
            end
            tick();
        end
        axi.BREADY = 0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_simultaneous_write();
        test_read_during_commit();
        test_skewed_strobe();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
